// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequencing controller driving a bank of T flip-flops.
// Every change to Count comes from toggle enables; the controller supports
// parallel load, bounded up-count to a captured limit, down-count to zero,
// and abort, with a one-cycle Done pulse at the end of a completed run.

// Single T flip-flop with synchronous active-high reset.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  logic q_q;
  logic q_d;

  // Toggle when enabled, otherwise hold.
  always_comb begin
    q_d = q_q ^ t;
  end

  // Storage element; reset clears the bit.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// state | meaning
// IDLE  | waiting; Load (priority) or Start accepted, inputs captured
// LOAD  | one cycle; toggles drive Count to the captured load value
// RUN   | count one step per cycle until terminal or Stop
// DONE  | one cycle; Done pulse, then back to IDLE
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Load,
  input  logic             Up,
  input  logic             Stop,
  input  logic [WIDTH-1:0] Load_value,
  input  logic [WIDTH-1:0] Limit,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] T_vec,
  output logic             Busy,
  output logic             Done
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic             terminal;

  // Toggle chains for +1 and -1: a bit flips when all lower bits are 1 (up)
  // or all lower bits are 0 (down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & Count[i-1];
      t_dn[i] = t_dn[i-1] & ~Count[i-1];
    end
  end

  // Run ends at the captured limit going up, or at zero going down.
  always_comb begin
    terminal = dir_q ? (Count == lim_q) : (Count == '0);
  end

  // State and capture registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and capture logic; Load beats Start, terminal beats Stop.
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (Load) begin
          ld_d    = Load_value;
          state_d = S_LOAD;
        end else if (Start) begin
          lim_d   = Limit;
          dir_d   = Up;
          state_d = S_RUN;
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_RUN: begin
        if (terminal)  state_d = S_DONE;
        else if (Stop) state_d = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status decoded from state, toggles from state/Count/captures.
  always_comb begin
    T_vec = '0;
    Busy  = (state_q == S_LOAD) || (state_q == S_RUN);
    Done  = (state_q == S_DONE);
    unique case (state_q)
      S_LOAD: T_vec = Count ^ ld_q;
      S_RUN: begin
        if (!terminal && !Stop) T_vec = dir_q ? t_up : t_dn;
      end
      default: T_vec = '0;
    endcase
  end

  // The T flip-flop bank.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    tff_cell u_tff (
      .clk (Clk),
      .rst (Reset),
      .t   (T_vec[g]),
      .q   (Count[g])
    );
  end
endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of `WIDTH` T flip-flops, each with synchronous reset. The bank is instantiated inside this block, and every change to `Count` is produced by driving per-bit toggle enables. The controller provides parallel load, bounded up-counting to a programmable limit, down-counting to zero, and abort. A one-cycle completion pulse is produced for the surrounding datapath.

## Interface
Parameters:
- `WIDTH`, default 4: number of T flip-flops in the bank, and the width of all count and value buses.

Ports:
- `Clk`  in  1  single clock; every register updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset. It is applied to the controller FSM, to the capture registers, and to every T flip-flop in the bank.
- `Start`  in  1  begin a count run; sampled only in IDLE.
- `Load`  in  1  begin a parallel load; sampled only in IDLE; takes priority over `Start`.
- `Up`  in  1  direction: 1 = up toward the limit, 0 = down toward 0; captured at `Start`.
- `Stop`  in  1  abort a run; effective only in RUN.
- `Load_value`  in  WIDTH  load target; captured when `Load` is accepted.
- `Limit`  in  WIDTH  up-count terminal value; captured when `Start` is accepted.
- `Count`  out  WIDTH  Q outputs of the T flip-flop bank.
- `T_vec`  out  WIDTH  toggle enables currently driven into the bank (debug/observability).
- `Busy`  out  1  high while the state is LOAD or RUN.
- `Done`  out  1  high for exactly one cycle, while the state is DONE.

## Operation
- **States** (2-bit encoding): IDLE=00, LOAD=01, RUN=10, DONE=11.
- **Bank update:** on every edge, bit i of `Count` becomes `Count[i] ^ T_vec[i]`.
- **IDLE:**
  - `T_vec` = 0.
  - If `Load`=1: capture `Load_value` into `ld_reg`; next state is LOAD.
  - Else if `Start`=1: capture `Limit` into `lim_reg` and `Up` into `dir_reg`; next state is RUN.
  - Otherwise remain in IDLE.
- **LOAD:**
  - `T_vec` = `Count ^ ld_reg`, so after the edge `Count` equals `ld_reg`.
  - Next state is IDLE.
  - Exactly one cycle in this state.
- **RUN, terminal check first:**
  - The terminal condition is `Count == lim_reg` when `dir_reg`=1, or `Count == 0` when `dir_reg`=0.
  - If terminal: `T_vec` = 0; next state is DONE.
- **RUN, stop check second:**
  - Else if `Stop`=1: `T_vec` = 0; next state is IDLE.
  - No `Done` pulse is produced, and `Count` holds its current value.
- **RUN, otherwise:**
  - `T_vec[0]` = 1.
  - For up: `T_vec[i]` = AND of `Count[i-1:0]`.
  - For down: `T_vec[i]` = AND of `~Count[i-1:0]`.
  - The result is `Count` ±1 modulo 2^WIDTH.
- **DONE:** `T_vec` = 0; next state is IDLE unconditionally.
- **Wrap-around:** an up run that starts with `Count > lim_reg` counts through 2^WIDTH−1 → 0 and stops at `lim_reg`. A down run never wraps, because it stops at 0.
- **Start at terminal:** `Start` accepted while `Count` already equals the target gives one RUN cycle with no toggle, then DONE.
- **Inputs outside IDLE:**
  - `Start` and `Load` are ignored.
  - Changes on `Limit` and `Load_value` are ignored, because captured values are used.
  - `Stop` is ignored outside RUN.
- **Reset (any state, including mid-run):**
  - state = IDLE, `Count` = 0, `ld_reg` = 0, `lim_reg` = 0, `dir_reg` = 0.
  - `Busy` = 0, `Done` = 0, `T_vec` = 0.
  - Reset overrides every other input on that edge.

## Timing
- `Busy` and `Done` are decoded directly from the state register: no extra latency and no glitch paths from inputs.
- `T_vec` is combinational from state, `Count` and the capture registers. It does not depend combinationally on `Start` or `Load`; it depends on `Stop` only in RUN.
- **Load latency:** `Load` sampled at edge k → LOAD during cycle k..k+1 → `Count` = value after edge k+1 → IDLE after edge k+1.
- **Run latency, up from C to L** (distance n = (L−C) mod 2^WIDTH):
  - RUN after edge k.
  - Count increments on edges k+1 … k+n.
  - DONE after edge k+n+1; `Done` is high for that one cycle.
  - IDLE after edge k+n+2.
- **Down from C:** the same timing, with n = C.
- **Throughput:** a new `Start` or `Load` is accepted on the first IDLE cycle, i.e. 1 cycle after DONE or LOAD.

## Test plan
- **Reset then load:**
  - Stimulus: assert `Reset` 2 cycles → `Count`=0, `Busy`=0, `Done`=0.
  - Then `Load`=1 with `Load_value`=4'hA for one cycle.
  - Required: `Busy`=1 for 1 cycle, `Count`=4'hA after the second edge, `Done` never high.
- **Up run:**
  - Stimulus: `Count`=0, `Start`, `Up`=1, `Limit`=5.
  - Required: `Count` 1,2,3,4,5 on successive edges; `Done` high exactly one cycle, 7 edges after `Start`; `Busy` high 6 cycles; `Count` holds 5.
- **Down run and wrap:**
  - Down: load 3, `Start` with `Up`=0 → `Count` 2,1,0, then `Done`.
  - Wrap: load 14, `Start` with `Up`=1, `Limit`=2 → `Count` 15,0,1,2, then `Done`.
  - Required: `T_vec` = 4'b1111 on the 15→0 step.
- **Stop and simultaneous events:**
  - Stop: `Start` with `Limit`=9; assert `Stop` when `Count`=4 → IDLE next, `Count` stays 4, `Done` never asserts.
  - Simultaneous: assert `Load` and `Start` together → LOAD is taken.
  - Terminal vs. stop: `Stop` on the cycle `Count`==`Limit` → DONE is taken (terminal wins).
- **Start at terminal:**
  - Stimulus: `Count`=7, `Start` with `Limit`=7.
  - Required: one RUN cycle with `T_vec`=0, then `Done` for one cycle; `Count` unchanged.
- **Reset mid-run and ignored inputs:**
  - During an up run at `Count`=3, assert `Reset` → next cycle `Count`=0, IDLE, `Busy`=0, `Done`=0.
  - During RUN, toggle `Limit` and pulse `Load` → no effect on the run.
